// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU.
//   Single-cycle ops (ADD, SUB, NOT, AND, OR, XOR, SLT, EQ) register their
//   result and flags on the accepting edge. With ALU_SEQ_MUL_EN defined,
//   opcode 8 runs a WIDTH-cycle shift-add multiplier. Without it, opcode 8
//   is illegal.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready, op[3:0], a, b     : operation input handshake
//   out_valid/out_ready, result          : result output handshake
//   flag_z/n/c/v/err                     : status flags, registered with result
//
// state  | meaning
// S_IDLE | accepting work, single-cycle ops complete here
// S_MUL  | shift-add multiply in progress, r_cnt steps remaining
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_err
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_NOT = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_z, r_n, r_c, r_v, r_err;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_load_single;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_res;
  logic             w_mul_v;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v, w_err;

  assign w_accept      = in_valid && in_ready;
  assign w_load_single = w_accept && !w_is_mul;

  // Single-cycle datapath; carry/borrow come from the extra top bit.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (op)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT: w_res = ~a;
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_EQ:  w_res = {{(WIDTH-1){1'b0}}, (a == b)};
      default: w_err = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam int         CW     = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
  state_t r_state, w_state_nxt;

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_is_mul   = (op == OP_MUL);
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
  // Last step is the one that takes the counter from 1 to 0.
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == CW'(1));
  assign w_mul_res  = w_acc_nxt[WIDTH-1:0];
  assign w_mul_v    = |w_acc_nxt[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:  if (w_mul_done)           w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = rst && (r_state == S_IDLE) && (!r_out_valid || out_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= CW'(WIDTH);
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_res  = '0;
  assign w_mul_v    = 1'b0;

  always_comb begin
    in_ready = rst && (!r_out_valid || out_ready);
  end
`endif

  // Result/flag register. A new load wins over the output handshake so
  // back-to-back ops never leave a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      {r_z, r_n, r_c, r_v, r_err} <= '0;
    end else if (w_load_single) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_z         <= ~|w_res;
      r_n         <= w_res[WIDTH-1];
      r_c         <= w_c;
      r_v         <= w_v;
      r_err       <= w_err;
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_mul_res;
      r_z         <= ~|w_mul_res;
      r_n         <= w_mul_res[WIDTH-1];
      r_c         <= 1'b0;
      r_v         <= w_mul_v;
      r_err       <= 1'b0;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flag_z    = r_z;
  assign flag_n    = r_n;
  assign flag_c    = r_c;
  assign flag_v    = r_v;
  assign flag_err  = r_err;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic       flag_z, flag_n, flag_c, flag_v, flag_err;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .flag_err(flag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic [4:0] flg;   // {z, n, c, v, err}
  } vec_t;

  vec_t vecs[16];

  function automatic logic [4:0] flags();
    return {flag_z, flag_n, flag_c, flag_v, flag_err};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic mul_seq(input logic [3:0] ma, input logic [3:0] mb,
                         input logic [3:0] er, input logic [4:0] ef);
    @(negedge clk);
    in_valid = 1'b1; op = 4'd8; a = ma; b = mb; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ma; b = ~mb;
    chk("mul_ready_low_T", {31'd0, in_ready}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k < 4) begin
        chk("mul_busy_valid", {31'd0, out_valid}, 32'd0);
        chk("mul_busy_ready", {31'd0, in_ready}, 32'd0);
      end else begin
        chk("mul_done_valid", {31'd0, out_valid}, 32'd1);
        chk("mul_result", {28'd0, result}, {28'd0, er});
        chk("mul_flags", {27'd0, flags()}, {27'd0, ef});
        chk("mul_ready_after", {31'd0, in_ready}, 32'd1);
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;

    vecs[0]  = '{4'd0,  4'b1110, 4'b0001, 4'b1111, 5'b01000};
    vecs[1]  = '{4'd0,  4'b0111, 4'b0001, 4'b1000, 5'b01010};
    vecs[2]  = '{4'd0,  4'b1111, 4'b0001, 4'b0000, 5'b10100};
    vecs[3]  = '{4'd1,  4'b0011, 4'b0101, 4'b1110, 5'b01100};
    vecs[4]  = '{4'd1,  4'b1000, 4'b0001, 4'b0111, 5'b00010};
    vecs[5]  = '{4'd1,  4'b0101, 4'b0101, 4'b0000, 5'b10000};
    vecs[6]  = '{4'd2,  4'b1010, 4'b0000, 4'b0101, 5'b00000};
    vecs[7]  = '{4'd3,  4'b1100, 4'b1010, 4'b1000, 5'b01000};
    vecs[8]  = '{4'd4,  4'b1100, 4'b0011, 4'b1111, 5'b01000};
    vecs[9]  = '{4'd5,  4'b1010, 4'b1010, 4'b0000, 5'b10000};
    vecs[10] = '{4'd6,  4'b1110, 4'b0001, 4'b0001, 5'b00000};
    vecs[11] = '{4'd6,  4'b0001, 4'b1110, 4'b0000, 5'b10000};
    vecs[12] = '{4'd7,  4'b0101, 4'b0101, 4'b0001, 5'b00000};
    vecs[13] = '{4'd7,  4'b0101, 4'b0100, 4'b0000, 5'b10000};
    vecs[14] = '{4'd10, 4'b0110, 4'b0011, 4'b0000, 5'b10001};
    vecs[15] = '{4'd15, 4'b1111, 4'b1111, 4'b0000, 5'b10001};

    // Reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {28'd0, result}, 32'd0);
    chk("rst_flags", {27'd0, flags()}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1 chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Single-cycle vectors, back-to-back with out_ready high
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      #1 chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_result", i), {28'd0, result}, {28'd0, vecs[i].res});
      chk($sformatf("v%0d_flags", i), {27'd0, flags()}, {27'd0, vecs[i].flg});
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: ADD held for 3 cycles, then XOR accepted with out_ready
    @(negedge clk);
    in_valid = 1'b1; op = 4'd0; a = 4'b0010; b = 4'b0011; out_ready = 1'b0;
    @(posedge clk); #1;
    op = 4'd5; a = 4'b1100; b = 4'b0101;
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_result", {28'd0, result}, 32'h5);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk("bp_hold_result", {28'd0, result}, 32'h5);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_result", {28'd0, result}, 32'h9);
    chk("b2b_flags", {27'd0, flags()}, 32'b01000);
    @(posedge clk); #1;
    chk("b2b_drain", {31'd0, out_valid}, 32'd0);

`ifdef ALU_SEQ_MUL_EN
    mul_seq(4'b0101, 4'b0011, 4'b1111, 5'b01000);
    mul_seq(4'b0111, 4'b0011, 4'b0101, 5'b00010);
    // Start a MUL and reset two cycles in
    @(negedge clk);
    in_valid = 1'b1; op = 4'd8; a = 4'b0101; b = 4'b0011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
`else
    // opcode 8 is illegal without the multiplier
    @(negedge clk);
    in_valid = 1'b1; op = 4'd8; a = 4'b0011; b = 4'b0010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("op8_valid", {31'd0, out_valid}, 32'd1);
    chk("op8_result", {28'd0, result}, 32'd0);
    chk("op8_flags", {27'd0, flags()}, 32'b10001);
    // Hold a nonzero result under backpressure, then reset
    @(negedge clk);
    in_valid = 1'b1; op = 4'd0; a = 4'b0111; b = 4'b0001; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
`endif
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", {28'd0, result}, 32'd0);
    chk("mid_rst_flags", {27'd0, flags()}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1 chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    repeat (6) @(posedge clk);
    #1 chk("post_rst_no_result", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b1; op = 4'd0; a = 4'b0001; b = 4'b0010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_rst_add_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_add_result", {28'd0, result}, 32'h3);
    chk("post_rst_add_flags", {27'd0, flags()}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked sequential ALU for the digital-circuits lab track; the next generation of the 4-bit function-select ALU. Operands enter through a valid/ready port. Single-cycle ops produce a registered result plus status flags one cycle later. An optional multi-cycle shift-add multiplier is included. The block sits between a stimulus source (switches/testbench) and a display or consumer that applies backpressure.

## Interface
- `WIDTH`, default 4, operand/result width in bits, minimum 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `in_valid`  in  1  operand/opcode valid.
- `in_ready`  out  1  block can accept an operation this cycle.
- `op`  in  4  opcode.
- `a`  in  WIDTH  operand A, two's complement.
- `b`  in  WIDTH  operand B, two's complement.
- `out_valid`  out  1  result/flags valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  registered result.
- `flag_z`, `flag_n`, `flag_c`, `flag_v`, `flag_err`  out  1 each  zero, negative, carry/borrow, overflow, illegal-op.

## Operation
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 NOT: ~A.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SLT: result = 1 if A<B signed, else 0.
  - 7 EQ: result = 1 if A==B, else 0.
  - 8 MUL: low WIDTH bits of A×B.
  - 9–15: illegal.
- Arithmetic:
  - ADD/SUB are computed at WIDTH+1 bits.
  - flag_c = carry-out for ADD; flag_c = borrow (A<B unsigned) for SUB.
  - flag_v = signed overflow (operand signs agree, result sign differs; for SUB compare against ~B).
- MUL: operands are treated as unsigned bit patterns, so the low half is correct for signed operands too. flag_v = 1 if the unsigned upper WIDTH bits are nonzero. flag_c = 0.
- Logic, SLT, EQ: flag_c = flag_v = 0.
- All legal ops: flag_z = (result==0), flag_n = result[WIDTH-1].
- Illegal op: result = 0, flag_err = 1, flag_z = 1, all other flags 0. flag_err is 0 for legal ops.
- FSM states:
  - IDLE: accepts work. A single-cycle op writes result/flags and sets out_valid, staying in IDLE. MUL goes to MUL.
  - MUL: loads multiplicand, multiplier, a 2×WIDTH accumulator and counter = WIDTH. Each cycle: if the multiplier LSB is 1, add the shifted multiplicand; then shift; counter−1. When counter reaches 0: write result, set out_valid, go to IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready). An accept in the same cycle as an output handshake is legal; the new result replaces the old one without a bubble.
- While out_valid && !out_ready: result and flags hold stable and no new op is accepted.
- out_valid clears on an out_ready handshake unless a new single-cycle result is loaded in the same edge.

## Timing
- Reset (rst=0, async): state=IDLE, out_valid=0, result=0, all flags 0. in_ready=0 while rst is low and 1 on the first cycle after release.
- Reset during MUL aborts the operation; no result is produced.
- Single-cycle op latency: accepted at edge T, out_valid=1 after edge T.
- MUL latency: accepted at edge T, out_valid=1 after edge T+WIDTH. in_ready=0 from T through T+WIDTH−1.
- Throughput: one single-cycle op per clock with out_ready held high. One MUL per WIDTH+1 clocks.
- Inputs a, b, op are sampled only on an in_valid && in_ready edge. Changes during MUL are ignored.

## Configuration
- `ALU_SEQ_MUL_EN` defined: opcode 8 is the multi-cycle multiplier and the MUL state exists.
- `ALU_SEQ_MUL_EN` undefined: the multiplier datapath and MUL state are omitted. Opcode 8 is treated as illegal (flag_err=1, result=0, latency 1).

## Test plan
All scenarios use WIDTH=4 with `ALU_SEQ_MUL_EN` defined unless noted.
- ADD a=1110 (−2), b=0001 → one cycle later result=1111, n=1, z=0, c=0, v=0. ADD 0111+0001 → result=1000, v=1, n=1.
- SUB a=0011, b=0101 → result=1110, c=1, n=1. SLT 1110,0001 → result=0001. EQ 0101,0101 → result=0001.
- MUL 0101×0011 → out_valid exactly 4 cycles after accept, result=1111, v=0. MUL 0111×0011 → result=0101, v=1. in_ready=0 throughout.
- Backpressure: out_ready=0 for 3 cycles after an ADD → result stable, in_ready=0. Raise out_ready together with a new in_valid XOR → back-to-back results, no bubble.
- Reset mid-MUL: assert rst=0 two cycles into a MUL → out_valid, result and flags are immediately 0. After release, an ADD completes normally.
- op=1010 → result=0, flag_err=1, z=1. Without `ALU_SEQ_MUL_EN`, op=1000 → flag_err=1 after 1 cycle.
